// File: rtl/nx_outbound_arbiter.sv
// Outbound AXI4-stream arbiter: merges control and core 31-bit messages into
// 64-bit beats (two tagged words per beat), with bounded control priority and idle flush.
module nx_outbound_arbiter #(
  parameter int AXI4_DATA_WIDTH = 64,
  parameter int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH / 8,
  parameter int AXI4_ID_WIDTH   = 1,
  parameter int FLUSH_CYCLES    = 16,
  parameter int CTRL_BURST_MAX  = 4
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [30:0]                ctrl_data_i,
  input  logic                       ctrl_valid_i,
  output logic                       ctrl_ready_o,
  input  logic [30:0]                core_data_i,
  input  logic                       core_valid_i,
  output logic                       core_ready_o,
  output logic [AXI4_DATA_WIDTH-1:0] outbound_tdata_o,
  output logic [AXI4_STRB_WIDTH-1:0] outbound_tkeep_o,
  output logic [AXI4_STRB_WIDTH-1:0] outbound_tstrb_o,
  output logic [AXI4_ID_WIDTH-1:0]   outbound_tid_o,
  output logic                       outbound_tlast_o,
  output logic                       outbound_tvalid_o,
  input  logic                       outbound_tready_i
);

  localparam int WORD_W    = AXI4_DATA_WIDTH / 2;
  localparam int HALF_STRB = AXI4_STRB_WIDTH / 2;
  localparam logic [AXI4_STRB_WIDTH-1:0] KEEP_FULL  = {AXI4_STRB_WIDTH{1'b1}};
  localparam logic [AXI4_STRB_WIDTH-1:0] KEEP_LOW   = {{HALF_STRB{1'b0}}, {HALF_STRB{1'b1}}};
  localparam logic [7:0]                 FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
  localparam logic [3:0]                 BURST_MAX  = 4'(CTRL_BURST_MAX);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e                     state_r, state_nxt_s;
  logic [AXI4_DATA_WIDTH-1:0] tdata_r, tdata_nxt_s;
  logic [AXI4_STRB_WIDTH-1:0] tkeep_r, tkeep_nxt_s;
  logic [7:0]                 idle_r, idle_nxt_s;
  logic [3:0]                 burst_r;
  logic                       can_accept_s;
  logic                       grant_ctrl_s;
  logic                       grant_core_s;
  logic                       accept_ctrl_s;
  logic                       accept_core_s;
  logic                       accept_s;
  logic [WORD_W-1:0]          word_s;

  // Control wins unless it has already held the bus CTRL_BURST_MAX times in front of a waiting core word.
  assign can_accept_s  = (state_r != ST_FULL) || outbound_tready_i;
  assign grant_ctrl_s  = ctrl_valid_i && !(core_valid_i && (burst_r == BURST_MAX));
  assign grant_core_s  = core_valid_i && !grant_ctrl_s;
  assign accept_ctrl_s = can_accept_s && grant_ctrl_s;
  assign accept_core_s = can_accept_s && grant_core_s;
  assign accept_s      = accept_ctrl_s || accept_core_s;
  assign word_s        = grant_ctrl_s ? {1'b1, ctrl_data_i} : {1'b0, core_data_i};

  assign ctrl_ready_o      = rstn_i && accept_ctrl_s;
  assign core_ready_o      = rstn_i && accept_core_s;
  assign outbound_tdata_o  = tdata_r;
  assign outbound_tkeep_o  = tkeep_r;
  assign outbound_tstrb_o  = tkeep_r;
  assign outbound_tid_o    = {AXI4_ID_WIDTH{1'b0}};
  assign outbound_tlast_o  = 1'b1;
  assign outbound_tvalid_o = (state_r == ST_FULL);

  // Packer state and beat registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= ST_EMPTY;
      tdata_r <= {AXI4_DATA_WIDTH{1'b0}};
      tkeep_r <= {AXI4_STRB_WIDTH{1'b0}};
      idle_r  <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      tdata_r <= tdata_nxt_s;
      tkeep_r <= tkeep_nxt_s;
      idle_r  <= idle_nxt_s;
    end
  end

  // Consecutive control grants seen by a waiting core source, saturating.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      burst_r <= 4'd0;
    end else if (!core_valid_i || accept_core_s) begin
      burst_r <= 4'd0;
    end else if (accept_ctrl_s && (burst_r != BURST_MAX)) begin
      burst_r <= burst_r + 4'd1;
    end else begin
      burst_r <= burst_r;
    end
  end

  // Next packer state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) state_nxt_s = ST_HALF;
        else          state_nxt_s = ST_EMPTY;
      end
      ST_HALF: begin
        if (accept_s)                 state_nxt_s = ST_FULL;
        else if (idle_r == FLUSH_LAST) state_nxt_s = ST_FULL;
        else                          state_nxt_s = ST_HALF;
      end
      ST_FULL: begin
        if (!outbound_tready_i) state_nxt_s = ST_FULL;
        else if (accept_s)      state_nxt_s = ST_HALF;
        else                    state_nxt_s = ST_EMPTY;
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Beat contents and idle counter; a held beat only changes on its handshake.
  always_comb begin
    tdata_nxt_s = tdata_r;
    tkeep_nxt_s = tkeep_r;
    idle_nxt_s  = idle_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          tdata_nxt_s = {{WORD_W{1'b0}}, word_s};
          idle_nxt_s  = 8'd0;
        end else begin
          idle_nxt_s  = idle_r;
        end
      end
      ST_HALF: begin
        if (accept_s) begin
          tdata_nxt_s[AXI4_DATA_WIDTH-1:WORD_W] = word_s;
          tkeep_nxt_s = KEEP_FULL;
          idle_nxt_s  = 8'd0;
        end else if (idle_r == FLUSH_LAST) begin
          tdata_nxt_s[AXI4_DATA_WIDTH-1:WORD_W] = {WORD_W{1'b0}};
          tkeep_nxt_s = KEEP_LOW;
          idle_nxt_s  = 8'd0;
        end else begin
          idle_nxt_s  = idle_r + 8'd1;
        end
      end
      ST_FULL: begin
        if (outbound_tready_i && accept_s) begin
          tdata_nxt_s = {{WORD_W{1'b0}}, word_s};
          idle_nxt_s  = 8'd0;
        end else begin
          idle_nxt_s  = idle_r;
        end
      end
      default: begin
        tdata_nxt_s = {AXI4_DATA_WIDTH{1'b0}};
        tkeep_nxt_s = {AXI4_STRB_WIDTH{1'b0}};
        idle_nxt_s  = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_nx_outbound_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// word-queue reference model of the arbiter/packer.
module tb_nx_outbound_arbiter;

  localparam int FLUSH_CYCLES   = 16;
  localparam int CTRL_BURST_MAX = 4;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [30:0] ctrl_data_i = 31'd0;
  logic        ctrl_valid_i = 1'b0;
  logic        ctrl_ready_o;
  logic [30:0] core_data_i = 31'd0;
  logic        core_valid_i = 1'b0;
  logic        core_ready_o;
  logic [63:0] outbound_tdata_o;
  logic [7:0]  outbound_tkeep_o;
  logic [7:0]  outbound_tstrb_o;
  logic [0:0]  outbound_tid_o;
  logic        outbound_tlast_o;
  logic        outbound_tvalid_o;
  logic        outbound_tready_i = 1'b0;

  nx_outbound_arbiter #(
    .AXI4_DATA_WIDTH(64),
    .AXI4_STRB_WIDTH(8),
    .AXI4_ID_WIDTH  (1),
    .FLUSH_CYCLES   (FLUSH_CYCLES),
    .CTRL_BURST_MAX (CTRL_BURST_MAX)
  ) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .ctrl_data_i      (ctrl_data_i),
    .ctrl_valid_i     (ctrl_valid_i),
    .ctrl_ready_o     (ctrl_ready_o),
    .core_data_i      (core_data_i),
    .core_valid_i     (core_valid_i),
    .core_ready_o     (core_ready_o),
    .outbound_tdata_o (outbound_tdata_o),
    .outbound_tkeep_o (outbound_tkeep_o),
    .outbound_tstrb_o (outbound_tstrb_o),
    .outbound_tid_o   (outbound_tid_o),
    .outbound_tlast_o (outbound_tlast_o),
    .outbound_tvalid_o(outbound_tvalid_o),
    .outbound_tready_i(outbound_tready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one pending beat plus at most one lone word waiting for a partner.
  bit          m_out_valid = 1'b0;
  logic [63:0] m_out_data  = 64'd0;
  logic [7:0]  m_out_keep  = 8'd0;
  bit          m_have      = 1'b0;
  logic [31:0] m_partial   = 32'd0;
  int          m_idle      = 0;
  int          m_burst     = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_out_valid = 1'b0;
    m_have      = 1'b0;
    m_idle      = 0;
    m_burst     = 0;
  endtask

  // One cycle: drive on the falling edge, check just after, then advance the model to the next rising edge.
  task automatic step(input logic cv, input logic [30:0] cd,
                      input logic kv, input logic [30:0] kd, input logic tr);
    bit          can, gc, gk;
    logic [31:0] w;
    @(negedge clk_i);
    ctrl_valid_i = cv; ctrl_data_i = cd;
    core_valid_i = kv; core_data_i = kd;
    outbound_tready_i = tr;
    #1;
    can = !m_out_valid || tr;
    gc  = cv && !(kv && (m_burst >= CTRL_BURST_MAX));
    gk  = kv && !gc;
    chk("ctrl_ready", ctrl_ready_o, can && gc);
    chk("core_ready", core_ready_o, can && gk);
    chk("tvalid", outbound_tvalid_o, m_out_valid);
    chk("tlast", outbound_tlast_o, 1'b1);
    chk("tid", outbound_tid_o, 1'b0);
    if (m_out_valid) begin
      chk("tdata", outbound_tdata_o, m_out_data);
      chk("tkeep", outbound_tkeep_o, m_out_keep);
      chk("tstrb", outbound_tstrb_o, m_out_keep);
    end
    if (!kv) m_burst = 0;
    else if (can && gc) m_burst = (m_burst < CTRL_BURST_MAX) ? m_burst + 1 : m_burst;
    else if (can && gk) m_burst = 0;
    if (m_out_valid && tr) m_out_valid = 1'b0;
    if (can && (gc || gk)) begin
      w = gc ? {1'b1, cd} : {1'b0, kd};
      if (m_have) begin
        m_out_data  = {w, m_partial};
        m_out_keep  = 8'hFF;
        m_out_valid = 1'b1;
        m_have      = 1'b0;
      end else begin
        m_have    = 1'b1;
        m_partial = w;
        m_idle    = 0;
      end
    end else if (m_have) begin
      m_idle++;
      if (m_idle == FLUSH_CYCLES) begin
        m_out_data  = {32'd0, m_partial};
        m_out_keep  = 8'h0F;
        m_out_valid = 1'b1;
        m_have      = 1'b0;
      end
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 31'd0, 1'b0, 31'd0, 1'b1);
  endtask

  initial begin
    // Reset state, with both sources requesting.
    ctrl_valid_i = 1'b1;
    core_valid_i = 1'b1;
    outbound_tready_i = 1'b1;
    #2;
    chk("rst_tvalid", outbound_tvalid_o, 1'b0);
    chk("rst_tdata", outbound_tdata_o, 64'd0);
    chk("rst_tkeep", outbound_tkeep_o, 8'h00);
    chk("rst_ctrl_ready", ctrl_ready_o, 1'b0);
    chk("rst_core_ready", core_ready_o, 1'b0);
    ctrl_valid_i = 1'b0;
    core_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    model_clear();

    // Two control words form one full beat.
    step(1'b1, 31'h12, 1'b0, 31'd0, 1'b1);
    step(1'b1, 31'h34, 1'b0, 31'd0, 1'b1);
    step(1'b0, 31'd0, 1'b0, 31'd0, 1'b1);
    chk("t1_tvalid", outbound_tvalid_o, 1'b1);
    chk("t1_tdata", outbound_tdata_o, 64'h80000034_80000012);
    chk("t1_tkeep", outbound_tkeep_o, 8'hFF);

    // Lone core word flushes 16 cycles after acceptance.
    step(1'b0, 31'd0, 1'b1, 31'h5, 1'b1);
    idle_steps(16);
    chk("t2_not_early", outbound_tvalid_o, 1'b0);
    idle_steps(1);
    chk("t2_tvalid", outbound_tvalid_o, 1'b1);
    chk("t2_tdata", outbound_tdata_o, 64'h00000000_00000005);
    chk("t2_tkeep", outbound_tkeep_o, 8'h0F);

    // Both sources saturated: C,C,C,C,K repeating.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 31'(i), 1'b1, 31'(32'h100 + i), 1'b1);
      chk("t3_ctrl_grant", ctrl_ready_o, (i % 5) != 4);
      chk("t3_core_grant", core_ready_o, (i % 5) == 4);
    end
    idle_steps(3);

    // Backpressure holds the beat; retire and accept in the same cycle.
    step(1'b1, 31'h1, 1'b0, 31'd0, 1'b0);
    step(1'b1, 31'h2, 1'b0, 31'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 31'h9, 1'b1, 31'h9, 1'b0);
      chk("t4_hold_ctrl", ctrl_ready_o, 1'b0);
      chk("t4_hold_core", core_ready_o, 1'b0);
      chk("t4_hold_data", outbound_tdata_o, 64'h80000002_80000001);
    end
    step(1'b1, 31'h7, 1'b0, 31'd0, 1'b1);
    chk("t4_retire_accept", ctrl_ready_o, 1'b1);
    step(1'b0, 31'd0, 1'b0, 31'd0, 1'b1);
    chk("t4_tvalid_after", outbound_tvalid_o, 1'b0);
    chk("t4_low_half", outbound_tdata_o[31:0], 32'h80000007);
    idle_steps(FLUSH_CYCLES + 1);

    // Mid-operation reset discards the partial beat.
    step(1'b0, 31'd0, 1'b1, 31'h1, 1'b1);
    @(negedge clk_i);
    rstn_i = 1'b0;
    ctrl_valid_i = 1'b1;
    core_valid_i = 1'b1;
    #1;
    chk("t5_tvalid", outbound_tvalid_o, 1'b0);
    chk("t5_tkeep", outbound_tkeep_o, 8'h00);
    chk("t5_ctrl_ready", ctrl_ready_o, 1'b0);
    chk("t5_core_ready", core_ready_o, 1'b0);
    ctrl_valid_i = 1'b0;
    core_valid_i = 1'b0;
    model_clear();
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    step(1'b0, 31'd0, 1'b1, 31'hA, 1'b1);
    step(1'b0, 31'd0, 1'b1, 31'hB, 1'b1);
    step(1'b0, 31'd0, 1'b0, 31'd0, 1'b1);
    chk("t5_tdata", outbound_tdata_o, 64'h0000000B_0000000A);

    // Core-only stream streams at full rate.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 31'd0, 1'b1, 31'(i), 1'b1);
      chk("t6_core_ready", core_ready_o, 1'b1);
      if (outbound_tvalid_o) begin
        chk("t6_tag_lo", outbound_tdata_o[31], 1'b0);
        chk("t6_tag_hi", outbound_tdata_o[63], 1'b0);
      end
    end
    idle_steps(FLUSH_CYCLES + 2);

    // Random traffic with random backpressure.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0, 31'($urandom()),
           $urandom_range(0, 2) != 0, 31'($urandom()),
           $urandom_range(0, 3) != 0);
    end
    idle_steps(FLUSH_CYCLES + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nx_outbound_arbiter.md
Name: nx_outbound_arbiter

Overview:
- Shares the 64-bit outbound AXI4-stream between two 32-bit message sources: the control responder and the nexus mesh output.
- Arbitrates one message per cycle.
- Packs two 32-bit words per beat, low word first. Word format is {is_ctrl, payload[30:0]}.
- A half-filled beat is flushed after a programmable idle timeout.
- Bounds control priority so the core stream cannot be starved.
- Sits between the control/core stream producers and the FPGA top-level outbound AXI4-stream port.

Parameters:
- AXI4_DATA_WIDTH, 64, outbound tdata width; only 64 is supported.
- AXI4_STRB_WIDTH, AXI4_DATA_WIDTH/8, tkeep/tstrb width.
- AXI4_ID_WIDTH, 1, tid width.
- FLUSH_CYCLES, 16, idle cycles in HALF before a partial beat is emitted; range 1..255.
- CTRL_BURST_MAX, 4, maximum consecutive control grants while core is waiting; range 1..15.

Ports:
- clk_i  input  1  clock
- rstn_i  input  1  reset, asynchronous, active-low
- ctrl_data_i  input  31  control message payload
- ctrl_valid_i  input  1  control message valid
- ctrl_ready_o  output  1  control message accepted
- core_data_i  input  31  core message payload
- core_valid_i  input  1  core message valid
- core_ready_o  output  1  core message accepted
- outbound_tdata_o  output  AXI4_DATA_WIDTH  packed beat
- outbound_tkeep_o  output  AXI4_STRB_WIDTH  byte keep
- outbound_tstrb_o  output  AXI4_STRB_WIDTH  byte strobe, always equal to tkeep
- outbound_tid_o  output  AXI4_ID_WIDTH  always 0
- outbound_tlast_o  output  1  always 1
- outbound_tvalid_o  output  1  beat valid
- outbound_tready_i  input  1  downstream ready

Behaviour:

Reset:
- Reset is asynchronous on rstn_i, active-low; clock is clk_i.
- Reset values: state EMPTY, tvalid 0, tdata 0, tkeep/tstrb 0, idle counter 0, burst counter 0.
- ctrl_ready_o and core_ready_o are forced to 0 while rstn_i is low.
- Reset mid-operation discards any partial or pending beat.

Packer states:
- EMPTY: no words held.
- HALF: low word held.
- FULL: beat registered; tvalid=1.

Acceptance:
- can_accept = (state != FULL) || outbound_tready_i. This is a combinational path from tready to the ready outputs.
- grant_ctrl = ctrl_valid_i && !(core_valid_i && burst == CTRL_BURST_MAX).
- grant_core = core_valid_i && !grant_ctrl.
- ctrl_ready_o = can_accept && grant_ctrl.
- core_ready_o = can_accept && grant_core.
- At most one ready is high per cycle.
- Ready may depend on valid. Valid must not depend on ready.

Accepted word:
- Control: {1'b1, ctrl_data_i}.
- Core: {1'b0, core_data_i}.

Burst counter:
- Increments on each accepted control word while core_valid_i = 1.
- Clears on an accepted core word, or on any cycle with core_valid_i = 0.
- Saturates at CTRL_BURST_MAX.

State transitions (per cycle):
- EMPTY + accept -> HALF: word into tdata[31:0]; idle counter cleared.
- HALF + accept -> FULL: word into tdata[63:32]; tkeep = 8'hFF.
- HALF + no accept:
  - Idle counter increments.
  - When the counter reaches FLUSH_CYCLES-1 -> FULL with tkeep = 8'h0F and tdata[63:32] = 0.
  - The partial beat therefore presents on the cycle after FLUSH_CYCLES idle cycles.
- FULL + tready + accept -> HALF: new word into low half; high half zeroed; idle counter cleared. Zero-bubble throughput.
- FULL + tready + no accept -> EMPTY.
- FULL + !tready -> hold. tdata/tkeep/tvalid are stable and both readies are 0.

Latency and output stability:
- Minimum latency, accept to tvalid: 1 cycle after the second word is accepted.
- tdata, tkeep and tstrb only change on a handshake or in a non-FULL state.

Test Plan:
1. Two consecutive control words 0x12 then 0x34, tready=1 -> one beat: tdata=0x80000034_80000012, tkeep=tstrb=8'hFF, tlast=1, tid=0.
2. Single core word 0x5 followed by idle -> tvalid rises exactly 16 cycles after acceptance (FLUSH_CYCLES=16): tdata=0x00000000_00000005, tkeep=8'h0F.
3. Both sources continuously valid, CTRL_BURST_MAX=4 -> accepted sequence C,C,C,C,K,C,C,C,C,K; five beats over 10 words.
4. FULL with tready=0 for 5 cycles -> both readies 0 and tdata stable. Then tready=1 with ctrl valid 0x7 -> beat retires and 0x80000007 lands in the low half the same cycle.
5. Assert rstn_i while in HALF holding 0x1 -> tvalid=0 and tkeep=0 immediately. After release, words 0xA and 0xB produce a beat of 0x0000000B_0000000A.
6. Core-only stream, 8 words 0..7 -> core_ready_o=1 every cycle; four beats, tdata[31] and tdata[63] always 0.
